// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and encodings for the register-file writeback arbiter.
// The register file uses the same width defaults.
package regfile_wb_arbiter_pkg;

    localparam int unsigned RF_DATA_W = 16;
    localparam int unsigned RF_ADDR_W = 3;
    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned R0_ADDR   = 0;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester handshakes, pipeline controls and register-file write port.
interface regfile_wb_arbiter_if import regfile_wb_arbiter_pkg::*; #(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_dest;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_dest;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              stall;
    logic              flush;
    logic              reg_write_en;
    logic [ADDR_W-1:0] reg_write_dest;
    logic [DATA_W-1:0] reg_write_data;
    logic [CNT_W-1:0]  conflict_cnt;

    modport master (
        output a_valid, a_dest, a_data, b_valid, b_dest, b_data, stall, flush,
        input  a_ready, b_ready, reg_write_en, reg_write_dest, reg_write_data, conflict_cnt
    );

    modport slave (
        input  a_valid, a_dest, a_data, b_valid, b_dest, b_data, stall, flush,
        output a_ready, b_ready, reg_write_en, reg_write_dest, reg_write_data, conflict_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant generator; last_grant only moves on a real conflict,
// so a lone requester never steals the other port's turn.
module regfile_wb_arbiter_rr_arb2 import regfile_wb_arbiter_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic hold,
    output logic gnt_a_c,
    output logic gnt_b_c
);
    grant_e last_grant_q, last_grant_d;

    always_comb begin
        gnt_a_c      = 1'b0;
        gnt_b_c      = 1'b0;
        last_grant_d = last_grant_q;
        if (!hold) begin
            if (req_a && req_b) begin
                if (last_grant_q == GRANT_B) begin
                    gnt_a_c      = 1'b1;
                    last_grant_d = GRANT_A;
                end else begin
                    gnt_b_c      = 1'b1;
                    last_grant_d = GRANT_B;
                end
            end else begin
                gnt_a_c = req_a;
                gnt_b_c = req_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto the single register-file
// write port, one registered write per cycle, and counts conflict cycles.
module regfile_wb_arbiter import regfile_wb_arbiter_pkg::*; #(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave wb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              hold_c;
    logic              gnt_a_c;
    logic              gnt_b_c;
    logic              reg_write_en_q,   reg_write_en_d;
    logic [ADDR_W-1:0] reg_write_dest_q, reg_write_dest_d;
    logic [DATA_W-1:0] reg_write_data_q, reg_write_data_d;
    logic [CNT_W-1:0]  conflict_cnt_q,   conflict_cnt_d;

    // flush outranks stall, but both simply freeze arbitration for the cycle
    assign hold_c = wb.stall | wb.flush;

    regfile_wb_arbiter_rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (wb.a_valid),
        .req_b   (wb.b_valid),
        .hold    (hold_c),
        .gnt_a_c (gnt_a_c),
        .gnt_b_c (gnt_b_c)
    );

    assign wb.a_ready = gnt_a_c & rst_n;
    assign wb.b_ready = gnt_b_c & rst_n;

    // writes to r0 are accepted and latched but never enabled
    always_comb begin
        reg_write_en_d   = 1'b0;
        reg_write_dest_d = reg_write_dest_q;
        reg_write_data_d = reg_write_data_q;
        conflict_cnt_d   = conflict_cnt_q;
        if (gnt_a_c) begin
            reg_write_dest_d = wb.a_dest;
            reg_write_data_d = wb.a_data;
            reg_write_en_d   = (wb.a_dest != ADDR_W'(R0_ADDR));
        end else if (gnt_b_c) begin
            reg_write_dest_d = wb.b_dest;
            reg_write_data_d = wb.b_data;
            reg_write_en_d   = (wb.b_dest != ADDR_W'(R0_ADDR));
        end
        if (wb.flush) begin
            reg_write_en_d = 1'b0;
        end
        if (wb.a_valid && wb.b_valid && !hold_c && (conflict_cnt_q != CNT_MAX)) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_en_q   <= 1'b0;
            reg_write_dest_q <= '0;
            reg_write_data_q <= '0;
            conflict_cnt_q   <= '0;
        end else begin
            reg_write_en_q   <= reg_write_en_d;
            reg_write_dest_q <= reg_write_dest_d;
            reg_write_data_q <= reg_write_data_d;
            conflict_cnt_q   <= conflict_cnt_d;
        end
    end

    assign wb.reg_write_en   = reg_write_en_q;
    assign wb.reg_write_dest = reg_write_dest_q;
    assign wb.reg_write_data = reg_write_data_q;
    assign wb.conflict_cnt   = conflict_cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued when a
// cycle is driven and compared after the following clock edge.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    typedef struct packed {
        logic        en;
        logic [2:0]  dest;
        logic [15:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    wr_t  sb[$];
    logic [2:0]  m_dest = 3'd0;
    logic [15:0] m_data = 16'd0;
    int          m_cnt  = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(16), .ADDR_W(3), .CNT_W(8)) wb ();
    regfile_wb_arbiter_if #(.DATA_W(16), .ADDR_W(3), .CNT_W(2)) ws ();

    regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .wb(wb.slave)
    );
    regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .wb(ws.slave)
    );

    task automatic drive(input logic av, input logic [2:0] ad, input logic [15:0] adat,
                         input logic bv, input logic [2:0] bd, input logic [15:0] bdat,
                         input logic st, input logic fl);
        wb.a_valid = av; wb.a_dest = ad; wb.a_data = adat;
        wb.b_valid = bv; wb.b_dest = bd; wb.b_data = bdat;
        wb.stall   = st; wb.flush  = fl;
    endtask

    // Queue the write the bench expects one edge later, given the expected grants.
    task automatic push_exp(input logic ea, input logic eb);
        wr_t e;
        e.en = 1'b0;
        if (ea) begin
            m_dest = wb.a_dest; m_data = wb.a_data; e.en = (wb.a_dest != 3'd0);
        end else if (eb) begin
            m_dest = wb.b_dest; m_data = wb.b_data; e.en = (wb.b_dest != 3'd0);
        end
        if (wb.flush) e.en = 1'b0;
        e.dest = m_dest;
        e.data = m_data;
        if (wb.a_valid && wb.b_valid && !wb.stall && !wb.flush && m_cnt < 255) m_cnt++;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        wr_t got;
        drive(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 1'b0, 1'b0);
        ws.a_valid = 1'b0; ws.a_dest = 3'd0; ws.a_data = 16'd0;
        ws.b_valid = 1'b0; ws.b_dest = 3'd0; ws.b_data = 16'd0;
        ws.stall = 1'b0; ws.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = {wb.reg_write_en, wb.reg_write_dest, wb.reg_write_data};
        checks++;
        if (got !== '0 || wb.conflict_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs: got en/dest/data=%h cnt=%0d want 0/0", got, wb.conflict_cnt);
        end
        checks++;
        if (wb.a_ready !== 1'b0 || wb.b_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got a=%b b=%b want 0 0", wb.a_ready, wb.b_ready);
        end
        drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        wr_t exp;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
            #3;
            checks++;
            if (wb.a_ready !== 1'b0 || wb.b_ready !== 1'b0) begin
                failures++;
                $display("FAIL idle_ready[%0d]: got a=%b b=%b want 0 0", i, wb.a_ready, wb.b_ready);
            end
            push_exp(1'b0, 1'b0);
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (wb.reg_write_en !== exp.en) begin
                failures++;
                $display("FAIL idle_en[%0d]: got %b want %b", i, wb.reg_write_en, exp.en);
            end
        end
    endtask

    task automatic test_a_only();
        wr_t exp;
        drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        #3;
        checks++;
        if (wb.a_ready !== 1'b1 || wb.b_ready !== 1'b0) begin
            failures++;
            $display("FAIL a_only_ready: got a=%b b=%b want 1 0", wb.a_ready, wb.b_ready);
        end
        push_exp(1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        exp = sb.pop_front();
        checks++;
        if ({wb.reg_write_en, wb.reg_write_dest, wb.reg_write_data} !== exp) begin
            failures++;
            $display("FAIL a_only_write: got %b/%0d/%h want %b/%0d/%h", wb.reg_write_en,
                     wb.reg_write_dest, wb.reg_write_data, exp.en, exp.dest, exp.data);
        end
    endtask

    task automatic test_conflict();
        wr_t  exp;
        logic ea;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB, 1'b0, 1'b0);
            ea = (i % 2 == 0);
            #3;
            checks++;
            if (wb.a_ready !== ea || wb.b_ready !== !ea) begin
                failures++;
                $display("FAIL conflict_grant[%0d]: got a=%b b=%b want %b %b", i,
                         wb.a_ready, wb.b_ready, ea, !ea);
            end
            push_exp(ea, !ea);
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if ({wb.reg_write_en, wb.reg_write_dest, wb.reg_write_data} !== exp) begin
                failures++;
                $display("FAIL conflict_write[%0d]: got %b/%0d/%h want %b/%0d/%h", i, wb.reg_write_en,
                         wb.reg_write_dest, wb.reg_write_data, exp.en, exp.dest, exp.data);
            end
        end
        drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        checks++;
        if (wb.conflict_cnt !== 8'(m_cnt) || m_cnt != 4) begin
            failures++;
            $display("FAIL conflict_cnt: got %0d want 4 (model %0d)", wb.conflict_cnt, m_cnt);
        end
    endtask

    task automatic test_r0_discard();
        wr_t exp;
        drive(1'b0, 3'd0, 16'd0, 1'b1, 3'd0, 16'hFFFF, 1'b0, 1'b0);
        #3;
        checks++;
        if (wb.a_ready !== 1'b0 || wb.b_ready !== 1'b1) begin
            failures++;
            $display("FAIL r0_ready: got a=%b b=%b want 0 1", wb.a_ready, wb.b_ready);
        end
        push_exp(1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        exp = sb.pop_front();
        checks++;
        if ({wb.reg_write_en, wb.reg_write_dest, wb.reg_write_data} !== exp) begin
            failures++;
            $display("FAIL r0_write: got %b/%0d/%h want %b/%0d/%h", wb.reg_write_en,
                     wb.reg_write_dest, wb.reg_write_data, exp.en, exp.dest, exp.data);
        end
    endtask

    // Stall cycles then flush cycles; nothing may be granted or counted.
    task automatic test_stall_flush();
        wr_t  exp;
        logic bv, st, fl;
        for (int i = 0; i < 5; i++) begin
            bv = (i != 0);
            st = (i < 3) || (i == 4);
            fl = (i >= 3);
            drive(1'b1, 3'd4, 16'h4444, bv, 3'd5, 16'h5555, st, fl);
            #3;
            checks++;
            if (wb.a_ready !== 1'b0 || wb.b_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_ready[%0d]: got a=%b b=%b want 0 0", i, wb.a_ready, wb.b_ready);
            end
            push_exp(1'b0, 1'b0);
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (wb.reg_write_en !== exp.en || wb.conflict_cnt !== 8'(m_cnt)) begin
                failures++;
                $display("FAIL hold_write[%0d]: got en=%b cnt=%0d want en=%b cnt=%0d", i,
                         wb.reg_write_en, wb.conflict_cnt, exp.en, m_cnt);
            end
        end
        drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    endtask

    // Same destination from both ports: A wins first (last conflict went to B), B lands last.
    task automatic test_same_dest();
        wr_t  exp;
        logic ea;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'd5, 16'h1111, 1'b1, 3'd5, 16'h2222, 1'b0, 1'b0);
            ea = (i == 0);
            #3;
            checks++;
            if (wb.a_ready !== ea || wb.b_ready !== !ea) begin
                failures++;
                $display("FAIL same_dest_grant[%0d]: got a=%b b=%b want %b %b", i,
                         wb.a_ready, wb.b_ready, ea, !ea);
            end
            push_exp(ea, !ea);
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if ({wb.reg_write_en, wb.reg_write_dest, wb.reg_write_data} !== exp) begin
                failures++;
                $display("FAIL same_dest_write[%0d]: got %b/%0d/%h want %b/%0d/%h", i, wb.reg_write_en,
                         wb.reg_write_dest, wb.reg_write_data, exp.en, exp.dest, exp.data);
            end
        end
        drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        int exp_cnt;
        for (int k = 1; k <= 5; k++) begin
            ws.a_valid = 1'b1; ws.a_dest = 3'd1; ws.a_data = 16'hA5A5;
            ws.b_valid = 1'b1; ws.b_dest = 3'd2; ws.b_data = 16'h5A5A;
            @(posedge clk); #1;
            exp_cnt = (k < 3) ? k : 3;
            checks++;
            if (ws.conflict_cnt !== 2'(exp_cnt)) begin
                failures++;
                $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, ws.conflict_cnt, exp_cnt);
            end
        end
        ws.a_valid = 1'b0;
        ws.b_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        wr_t exp;
        drive(1'b1, 3'd6, 16'h5A5A, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        #3;
        push_exp(1'b1, 1'b0);
        @(posedge clk); #1;
        exp = sb.pop_front();
        checks++;
        if ({wb.reg_write_en, wb.reg_write_dest, wb.reg_write_data} !== exp) begin
            failures++;
            $display("FAIL pre_reset_write: got %b/%0d/%h want %b/%0d/%h", wb.reg_write_en,
                     wb.reg_write_dest, wb.reg_write_data, exp.en, exp.dest, exp.data);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (wb.reg_write_en !== 1'b0 || wb.reg_write_dest !== 3'd0 ||
            wb.reg_write_data !== 16'd0 || wb.conflict_cnt !== 8'd0) begin
            failures++;
            $display("FAIL async_reset: got en=%b dest=%0d data=%h cnt=%0d want 0 0 0 0",
                     wb.reg_write_en, wb.reg_write_dest, wb.reg_write_data, wb.conflict_cnt);
        end
        checks++;
        if (wb.a_ready !== 1'b0 || ws.conflict_cnt !== 2'd0) begin
            failures++;
            $display("FAIL async_reset_ready: got a_ready=%b sat_cnt=%0d want 0 0",
                     wb.a_ready, ws.conflict_cnt);
        end
        drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        m_dest = 3'd0; m_data = 16'd0; m_cnt = 0;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_a_only();
        test_conflict();
        test_r0_discard();
        test_stall_flush();
        test_same_dest();
        test_saturation();
        test_async_reset();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
